// File: rtl/mem_stage_vl_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, bus field
// offsets, load opcodes and FSM state encoding.
package mem_stage_vl_pkg;

    localparam int unsigned DefDw  = 32;
    localparam int unsigned DefPcw = 32;
    localparam int unsigned DefRw  = 5;

    // exe_to_mem_bus = {ld_op, alu_result, res_from_mem, req_issued, gr_we, dest, pc}
    function automatic int unsigned exe_bus_w(int unsigned dw, int unsigned rw, int unsigned pcw);
        return 3 + dw + 3 + rw + pcw;
    endfunction

    // mem_to_wb_bus = {gr_we, dest, final_result, pc}
    function automatic int unsigned wb_bus_w(int unsigned dw, int unsigned rw, int unsigned pcw);
        return 1 + rw + dw + pcw;
    endfunction

    // Load opcodes; 101..111 fall back to a full-word load.
    localparam logic [2:0] LdW  = 3'b000;
    localparam logic [2:0] LdB  = 3'b001;
    localparam logic [2:0] LdH  = 3'b010;
    localparam logic [2:0] LdBu = 3'b011;
    localparam logic [2:0] LdHu = 3'b100;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StHold    = 2'd2,
        StDiscard = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_stage_vl_load_extend.sv
// Sub-word load extraction: selects the addressed byte/halfword and applies
// sign or zero extension.
module mem_stage_vl_load_extend
    import mem_stage_vl_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [2:0]    ld_op_i,
    input  logic [1:0]    offset_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte lane select by address offset.
    always_comb begin
        byte_sel = data_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = data_i[7:0];
            2'd1: byte_sel = data_i[15:8];
            2'd2: byte_sel = data_i[23:16];
            2'd3: byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
    end

    assign half_sel = offset_i[1] ? data_i[31:16] : data_i[15:0];

    // Extension according to the load opcode.
    always_comb begin
        result_o = data_i;
        case (ld_op_i)
            LdB:     result_o = {{(DW-8){byte_sel[7]}}, byte_sel};
            LdH:     result_o = {{(DW-16){half_sel[15]}}, half_sel};
            LdBu:    result_o = {{(DW-8){1'b0}}, byte_sel};
            LdHu:    result_o = {{(DW-16){1'b0}}, half_sel};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_vl.sv
// MEM pipeline stage with variable-latency data-SRAM response. Holds the
// response while WB stalls and swallows the stale response after a flush.
module mem_stage_vl
    import mem_stage_vl_pkg::*;
#(
    parameter  int unsigned DW        = DefDw,
    parameter  int unsigned PCW       = DefPcw,
    parameter  int unsigned RW        = DefRw,
    localparam int unsigned EXE_BUS_W = 3 + DW + 3 + RW + PCW,
    localparam int unsigned WB_BUS_W  = 1 + RW + DW + PCW,
    localparam int unsigned FWD_BUS_W = 2 + RW + DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exe_to_mem_valid,
    output logic                 mem_allow_in,
    input  logic [EXE_BUS_W-1:0] exe_to_mem_bus,
    input  logic                 wb_allow_in,
    output logic                 mem_to_wb_valid,
    output logic [WB_BUS_W-1:0]  mem_to_wb_bus,
    input  logic                 data_sram_data_ok,
    input  logic [DW-1:0]        data_sram_rdata,
    input  logic                 flush,
    output logic [FWD_BUS_W-1:0] mem_fwd_bus
);

    localparam int unsigned PcLsb     = 0;
    localparam int unsigned DestLsb   = PCW;
    localparam int unsigned GrWeBit   = PCW + RW;
    localparam int unsigned ReqBit    = GrWeBit + 1;
    localparam int unsigned ResMemBit = ReqBit + 1;
    localparam int unsigned AluLsb    = ResMemBit + 1;
    localparam int unsigned LdOpLsb   = AluLsb + DW;

    logic [EXE_BUS_W-1:0] mem_reg_q;
    logic                 mem_valid_q;
    logic                 mem_valid_d;
    mem_state_e           state_q;
    logic [DW-1:0]        rdata_buf_q;

    logic [2:0]     mem_ld_op;
    logic [DW-1:0]  mem_alu_result;
    logic           mem_res_from_mem;
    logic           mem_req_issued;
    logic           mem_gr_we;
    logic [RW-1:0]  mem_dest;
    logic [PCW-1:0] mem_pc;

    logic          need_data;
    logic          mem_ready_go;
    logic          accept;
    logic          start_req;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] load_result;
    logic [DW-1:0] final_result;
    logic          fwd_valid;
    logic          fwd_block;

    assign mem_ld_op        = mem_reg_q[LdOpLsb +: 3];
    assign mem_alu_result   = mem_reg_q[AluLsb +: DW];
    assign mem_res_from_mem = mem_reg_q[ResMemBit];
    assign mem_req_issued   = mem_reg_q[ReqBit];
    assign mem_gr_we        = mem_reg_q[GrWeBit];
    assign mem_dest         = mem_reg_q[DestLsb +: RW];
    assign mem_pc           = mem_reg_q[PcLsb +: PCW];

    // Handshake: a request-carrying instruction waits for data_ok, or uses the held buffer.
    assign need_data    = mem_valid_q && mem_req_issued;
    assign mem_ready_go = !need_data || ((state_q == StWait) && data_sram_data_ok) ||
                          (state_q == StHold);
    assign mem_allow_in = (state_q != StDiscard) &&
                          (!mem_valid_q || (mem_ready_go && wb_allow_in));
    assign accept       = mem_allow_in && exe_to_mem_valid;
    assign start_req    = accept && !flush && exe_to_mem_bus[ReqBit];

    assign mem_to_wb_valid = mem_valid_q && mem_ready_go && !flush;

    // Valid bit next state: flush kills, otherwise follow EXE when allowed in.
    always_comb begin
        mem_valid_d = mem_valid_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allow_in) begin
            mem_valid_d = exe_to_mem_valid;
        end
    end

    // Stage register and valid bit; the payload only moves on an actual transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            mem_reg_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            if (accept) begin
                mem_reg_q <= exe_to_mem_bus;
            end
        end
    end

    // Response-tracking FSM; DISCARD absorbs the response of a flushed request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rdata_buf_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_req) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (flush) begin
                        state_q <= data_sram_data_ok ? StIdle : StDiscard;
                    end else if (data_sram_data_ok) begin
                        if (wb_allow_in) begin
                            state_q <= start_req ? StWait : StIdle;
                        end else begin
                            state_q     <= StHold;
                            rdata_buf_q <= data_sram_rdata;
                        end
                    end
                end
                StHold: begin
                    if (flush) begin
                        state_q <= StIdle;
                    end else if (wb_allow_in) begin
                        state_q <= start_req ? StWait : StIdle;
                    end
                end
                StDiscard: begin
                    if (data_sram_data_ok) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_data = (state_q == StHold) ? rdata_buf_q : data_sram_rdata;

    mem_stage_vl_load_extend #(
        .DW (DW)
    ) u_load_extend (
        .ld_op_i  (mem_ld_op),
        .offset_i (mem_alu_result[1:0]),
        .data_i   (mem_data),
        .result_o (load_result)
    );

    assign final_result = mem_res_from_mem ? load_result : mem_alu_result;

    assign mem_to_wb_bus = {mem_gr_we, mem_dest, final_result, mem_pc};

    // Bypass info for ID; block means the load result is not yet available.
    assign fwd_valid   = mem_valid_q && mem_gr_we && (mem_dest != '0);
    assign fwd_block   = fwd_valid && mem_res_from_mem && !mem_ready_go;
    assign mem_fwd_bus = {fwd_valid, fwd_block, mem_dest, final_result};

endmodule

// File: doc/mem_stage_vl.md
Name: mem_stage_vl

Overview:
Next-generation MEM pipeline stage for the in-order LoongArch core. It sits between EXE and WB and accepts a variable-latency data-SRAM response through a data_ok handshake instead of the fixed one-cycle BRAM read. It extracts and sign- or zero-extends sub-word loads and buffers read data while WB stalls. It drops the in-flight response on a pipeline flush and exposes a forwarding/blocking bus for ID hazard logic.

Parameters:
DW, 32, datapath / GPR width
PCW, 32, PC width
RW, 5, register index width
EXE_BUS_W, 3+DW+3+RW+PCW, exe_to_mem_bus width (derived)
WB_BUS_W, 1+RW+DW+PCW, mem_to_wb_bus width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
exe_to_mem_valid  in  1  EXE holds a valid instruction
mem_allow_in  out  1  MEM can accept from EXE this cycle
exe_to_mem_bus  in  EXE_BUS_W  {ld_op[2:0], alu_result[DW-1:0], res_from_mem, req_issued, gr_we, dest[RW-1:0], pc[PCW-1:0]}
wb_allow_in  in  1  WB can accept
mem_to_wb_valid  out  1  MEM output valid
mem_to_wb_bus  out  WB_BUS_W  {gr_we, dest, final_result, pc}
data_sram_data_ok  in  1  read/write response returned this cycle
data_sram_rdata  in  DW  response data, valid when data_ok
flush  in  1  kill the MEM instruction (exception/ertn from WB)
mem_fwd_bus  out  2+RW+DW  {fwd_valid, fwd_block, dest, final_result} for ID bypass

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset.
- Reset values: mem_valid=0, state=IDLE, rdata_buf=0, mem_reg=0. Outputs mem_to_wb_valid=0, mem_allow_in=1, mem_fwd_bus fwd_valid=0.
- Handshake:
  - mem_allow_in = !mem_valid || (mem_ready_go && wb_allow_in), forced 0 when state==DISCARD.
  - mem_reg latches exe_to_mem_bus only when mem_allow_in && exe_to_mem_valid. It holds otherwise, unlike the free-running previous stage register.
  - mem_valid <= exe_to_mem_valid when mem_allow_in. It clears on flush.
- need_data = mem_valid && req_issued. Both loads and stores that issued a request wait for data_ok.
- mem_ready_go = !need_data || data_sram_data_ok (in WAIT) || state==HOLD.
- mem_to_wb_valid = mem_valid && mem_ready_go && !flush.
- State machine:
  - IDLE: a new instruction with req_issued goes to WAIT. Otherwise stay in IDLE.
  - WAIT: on data_ok with wb_allow_in, go to IDLE, or directly back to WAIT if the next instruction has req_issued. On data_ok without wb_allow_in, capture rdata_buf and go to HOLD. On flush without data_ok, go to DISCARD. On flush with data_ok, go to IDLE.
  - HOLD: when wb_allow_in, go to IDLE or WAIT per the incoming instruction. On flush, go to IDLE.
  - DISCARD: wait for data_ok, then go to IDLE. No output; mem_allow_in=0. This guarantees the stale response is never paired with a younger load.
- Load extraction: mem_data = (state==HOLD) ? rdata_buf : data_sram_rdata. Offset = alu_result[1:0].
  - ld_op 000 LD.W: whole word.
  - ld_op 001 LD.B: byte[offset] sign-extended.
  - ld_op 010 LD.H: halfword[offset[1]] sign-extended.
  - ld_op 011 LD.BU: byte zero-extended.
  - ld_op 100 LD.HU: halfword zero-extended.
  - ld_op 101-111: treated as LD.W.
  - Misaligned detection is not handled here; it is done in EXE.
- final_result = res_from_mem ? extracted load : alu_result.
- Forwarding:
  - fwd_valid = mem_valid && gr_we && dest!=0.
  - fwd_block = fwd_valid && res_from_mem && !mem_ready_go, meaning the load data is not yet available and ID must stall.
- Simultaneous events: flush has priority over every transition except the DISCARD/IDLE choice above. A reset mid-WAIT returns to IDLE; the memory side is reset by the same signal.

Decomposition:
- Shared package/header: bus width macros, field offsets, LD_* opcode constants, state encodings.
- One sub-module, load_extend: combinational offset select plus sign/zero extension, parametrised by DW.

Test Plan:
1. LD.W at 0x1000, data_ok 3 cycles later with rdata 0x89ABCDEF, WB ready -> mem_to_wb_valid only in the data_ok cycle, final_result 0x89ABCDEF, fwd_block=1 for the 3 wait cycles.
2. LD.B offset 3, rdata 0x80FF_1234 -> 0xFFFFFF80. LD.BU same -> 0x00000080. LD.H offset 2 -> 0xFFFF80FF. LD.HU offset 0 -> 0x00001234.
3. data_ok arrives while wb_allow_in=0 for 2 cycles, and rdata changes after the data_ok cycle -> HOLD, buffered value delivered unchanged once WB accepts, mem_allow_in=0 meanwhile.
4. flush in WAIT, data_ok 2 cycles later -> DISCARD, no mem_to_wb_valid, mem_allow_in=0 until data_ok, then IDLE.
5. Back-to-back ALU ops (req_issued=0) with wb_allow_in=1 -> one per cycle, final_result=alu_result, no stalls.
6. Reset asserted during WAIT -> next cycle mem_valid=0, state IDLE, mem_to_wb_valid=0, mem_allow_in=1.
